demux_1x8_deser: RTL and testbench



---
 rtl/demux_pkg.sv | 13 +
 rtl/demux_idx_counter.sv | 42 ++++
 rtl/demux_1x8_deser.sv | 133 +++++++++++++
 tb/tb_demux_1x8_deser.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the serial-to-parallel demultiplexer.
//   state_e      : frame FSM state encoding (StIdle / StShift)
//   DefaultWidth : default number of output positions
package demux_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } state_e;

    localparam int unsigned DefaultWidth = 8;

endpackage

// File: rtl/demux_idx_counter.sv
// Write-position counter for the deserializer.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   clr  : synchronous clear to 0 (wins over en)
//   en   : advance by one; wraps naturally since WIDTH is a power of two
//   idx  : current count
//   tc   : terminal count, high when idx == WIDTH-1
module demux_idx_counter #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned SEL_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [SEL_W-1:0] idx,
    output logic             tc
);

    logic [SEL_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign idx = cnt_q;
    assign tc  = (cnt_q == SEL_W'(WIDTH - 1));

endmodule

// File: rtl/demux_1x8_deser.sv
// Serial-to-parallel deserializer: routes a serial bit stream into WIDTH
// output positions (LSB first) and presents the assembled word with a
// one-cycle valid strobe.
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   start      : opens a frame / restarts an open frame (flags err_abort)
//   din        : serial data bit
//   din_valid  : din accepted this cycle while busy and start is low
//   clr_err    : clears err_abort (a simultaneous set wins)
//   dout       : registered assembled word, held until the next frame completes
//   dout_valid : one-cycle pulse when dout is updated
//   busy       : frame open
//   idx        : position the next accepted bit is written to
//   err_abort  : sticky, set when an open frame is restarted by start
module demux_1x8_deser
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    localparam int unsigned SEL_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clr_err,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             busy,
    output logic [SEL_W-1:0] idx,
    output logic             err_abort
);

    state_e state_d, state_q;

    logic [WIDTH-1:0] shadow_d, shadow_q;
    logic [WIDTH-1:0] dout_d, dout_q;
    logic             dout_valid_d, dout_valid_q;
    logic             err_d, err_q;

    logic accept;   // bit accepted this cycle
    logic last;     // accepted bit is the final one of the frame
    logic abort;    // start while a frame is open
    logic idx_tc;

    demux_idx_counter #(
        .WIDTH(WIDTH)
    ) u_idx_counter (
        .clk(clk),
        .rst(rst),
        .clr(start),
        .en (accept),
        .idx(idx),
        .tc (idx_tc)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; start outranks din_valid in both states
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (!start && din_valid && idx_tc) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy   = (state_q == StShift);
        accept = busy && din_valid && !start;
        last   = accept && idx_tc;
        abort  = busy && start;
    end

    // Datapath next state
    always_comb begin
        shadow_d     = shadow_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        if (start) begin
            shadow_d = '0;
        end else if (accept) begin
            shadow_d[idx] = din;
            if (last) begin
                dout_d       = {din, shadow_q[WIDTH-2:0]};
                dout_valid_d = 1'b1;
            end
        end

        err_d = err_q;
        if (abort) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            err_q        <= err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign err_abort  = err_q;

endmodule

// File: tb/tb_demux_1x8_deser.sv
module tb_demux_1x8_deser;

    localparam int unsigned W  = 8;
    localparam int unsigned SW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          din;
    logic          din_valid;
    logic          clr_err;
    logic [W-1:0]  dout;
    logic          dout_valid;
    logic          busy;
    logic [SW-1:0] idx;
    logic          err_abort;

    always #5 clk = ~clk;

    demux_1x8_deser #(
        .WIDTH(W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .din       (din),
        .din_valid (din_valid),
        .clr_err   (clr_err),
        .dout      (dout),
        .dout_valid(dout_valid),
        .busy      (busy),
        .idx       (idx),
        .err_abort (err_abort)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: an open flag plus the list of bits received so far.
    bit           m_open = 1'b0;
    bit           m_bits[$];
    logic [W-1:0] m_dout = '0;
    bit           m_dv   = 1'b0;
    bit           m_err  = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit s, input bit v, input bit d, input bit c);
        logic [W-1:0] word;
        bit           set_err;
        if (r) begin
            m_open = 1'b0;
            m_bits.delete();
            m_dout = '0;
            m_dv   = 1'b0;
            m_err  = 1'b0;
        end else begin
            m_dv    = 1'b0;
            set_err = m_open && s;
            if (s) begin
                m_open = 1'b1;
                m_bits.delete();
            end else if (m_open && v) begin
                m_bits.push_back(d);
                if (m_bits.size() == W) begin
                    word = '0;
                    for (int k = 0; k < int'(W); k++) begin
                        if (m_bits[k]) word = word + (W'(1) << k);
                    end
                    m_dout = word;
                    m_dv   = 1'b1;
                    m_open = 1'b0;
                    m_bits.delete();
                end
            end
            if (set_err)  m_err = 1'b1;
            else if (c)   m_err = 1'b0;
        end
    endtask

    // Apply one cycle of inputs, advance the model, and compare all outputs.
    task automatic cycle(input bit r, input bit s, input bit v, input bit d, input bit c);
        rst       = r;
        start     = s;
        din_valid = v;
        din       = d;
        clr_err   = c;
        @(posedge clk);
        model_step(r, s, v, d, c);
        #1;
        check_eq("dout",       dout,       m_dout);
        check_eq("dout_valid", dout_valid, m_dv);
        check_eq("busy",       busy,       m_open);
        check_eq("idx",        idx,        m_bits.size());
        check_eq("err_abort",  err_abort,  m_err);
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int gap);
        for (int k = 0; k < int'(W); k++) begin
            cycle(0, 0, 1, w[k], 0);
            if (k < int'(W) - 1) begin
                check_eq("no_early_dv", dout_valid, 1'b0);
                for (int g = 0; g < gap; g++) cycle(0, 0, 0, 1, 0);
            end
        end
    endtask

    initial begin
        logic [W-1:0] w;

        // Reset defaults
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        check_eq("rst_dout", dout, 8'h00);
        check_eq("rst_busy", busy, 1'b0);

        // Continuous frame 1,0,1,0,0,1,0,1 -> A5; din_valid with start is ignored
        cycle(0, 1, 1, 1, 0);
        check_eq("start_busy", busy, 1'b1);
        check_eq("start_idx", idx, 0);
        send_bits(8'hA5, 0);
        check_eq("a5_dout", dout, 8'hA5);
        check_eq("a5_dv", dout_valid, 1'b1);
        check_eq("a5_busy", busy, 1'b0);
        cycle(0, 0, 1, 1, 0);
        check_eq("a5_dv_pulse", dout_valid, 1'b0);
        check_eq("a5_hold", dout, 8'hA5);

        // Index sweep, back-to-back frames started on the dout_valid cycle
        cycle(0, 1, 0, 0, 0);
        for (int i = 0; i < int'(W); i++) begin
            w = W'(1) << i;
            send_bits(w, 0);
            check_eq("sweep_dout", dout, 64'(1) << i);
            check_eq("sweep_idx_wrap", idx, 0);
            if (i < int'(W) - 1) cycle(0, 1, 0, 0, 0);
        end

        // Gaps in din_valid
        cycle(0, 1, 0, 0, 0);
        send_bits(8'h0F, 3);
        check_eq("gap_dout", dout, 8'h0F);
        check_eq("gap_dv", dout_valid, 1'b1);

        // Abort: start, 4 bits, start with din_valid=1 and clr_err=1 (set wins)
        cycle(0, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++) cycle(0, 0, 1, 1, 0);
        check_eq("pre_abort_idx", idx, 4);
        cycle(0, 1, 1, 1, 1);
        check_eq("abort_err", err_abort, 1'b1);
        check_eq("abort_idx", idx, 0);
        check_eq("abort_dout", dout, 8'h0F);
        check_eq("abort_busy", busy, 1'b1);
        send_bits(8'hFF, 0);
        check_eq("abort_ff", dout, 8'hFF);
        check_eq("err_sticky", err_abort, 1'b1);
        cycle(0, 0, 0, 0, 1);
        check_eq("clr_err", err_abort, 1'b0);

        // Reset mid-frame during the 5th bit
        cycle(0, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++) cycle(0, 0, 1, 1, 0);
        cycle(1, 0, 1, 1, 0);
        check_eq("mid_rst_dv", dout_valid, 1'b0);
        check_eq("mid_rst_dout", dout, 8'h00);
        check_eq("mid_rst_busy", busy, 1'b0);
        cycle(0, 1, 0, 0, 0);
        send_bits(8'h3C, 1);
        check_eq("post_rst_3c", dout, 8'h3C);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(199) == 0),
                  ($urandom_range(24) == 0),
                  ($urandom_range(2) != 0),
                  1'($urandom),
                  ($urandom_range(9) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
